step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Upstream timing stage for the drum datapath. Converts the registered set_bpm value into a
//  step rate and drives the 4-bit step index (timing) that selects one bit of each 8-step
//  instrument pattern. A 3-state play/pause/idle FSM and a phase accumulator produce step_tick,
//  bar_start and slow_clk. There is no divider: the accumulator adds INC every clk.
// PARAMETERS
//  CLK_HZ          50_000_000  clk frequency in Hz
//  STEPS_PER_BEAT  2           pattern steps per beat (2 = eighth notes)
//  MIN_BPM         30          floor applied to set_bpm
//  ACC_W           32          accumulator width; CLK_HZ*60 + 255*STEPS_PER_BEAT < 2**ACC_W
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-low reset
//  play       in   1  level: 1 = run, 0 = pause
//  rewind     in   1  pulse: return to idle (timing 0)
//  set_bpm    in   8  tempo in beats per minute, from the datapath bpm register
//  timing     out  4  0 = idle; 1..8 = current step
//  step_tick  out  1  one-cycle pulse on the cycle timing takes a new step value
//  bar_start  out  1  one-cycle pulse coincident with step_tick when timing becomes 1
//  slow_clk   out  1  step-rate square wave; high for the first half of each step
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - state=IDLE; acc=0; timing=0; step_tick=0; bar_start=0; slow_clk=0
//   - inc = MIN_BPM*STEPS_PER_BEAT
//  Reset wins over every other input.
//  inc register (updated every cycle):
//   - inc <= max(set_bpm, MIN_BPM) * STEPS_PER_BEAT
//   - A tempo change takes effect one cycle later. acc is not cleared.
//  THRESH = CLK_HZ*60; HALF = THRESH/2.
//  FSM states: IDLE, RUN, PAUSE.
//  Transition priority: reset > rewind > play.
//   IDLE:
//    - play=1 -> RUN. On the next cycle: timing=1, step_tick=1, bar_start=1, acc=0.
//    - Otherwise timing stays 0.
//   RUN:
//    - rewind=1 -> IDLE. Next cycle: timing=0, acc=0, no pulses.
//    - play=0 -> PAUSE. timing and acc freeze; no tick fires that cycle.
//    - Otherwise: if acc+inc >= THRESH:
//       - acc <= acc+inc-THRESH; step_tick=1; timing advances.
//       - timing wraps 8->1; bar_start=1 on the wrap.
//    - Else acc <= acc+inc.
//   PAUSE:
//    - rewind=1 -> IDLE.
//    - play=1 -> RUN. Accumulation resumes from the held acc; there is no immediate tick.
//  slow_clk (registered):
//   - equals (state!=IDLE) && (acc_next < HALF)
//   - Forced 0 in IDLE.
//  Boundaries:
//   - set_bpm=0 or any value below MIN_BPM is treated as MIN_BPM.
//   - rewind and play both high in IDLE -> stay IDLE. play still high on the next cycle -> restart.
//   - timing never takes values 9..15.
//   - step_tick and bar_start never last longer than one cycle.
// STRUCTURE
//  Shared package (drum_pkg):
//   - state encoding
//   - NUM_STEPS=8
//   - TIMING_IDLE=4'd0
//   - BPM_W=8
//  Sub-module bpm_phase_acc:
//   - contains inc register, accumulator, compare/subtract
//   - inputs: clk, reset, en, clr, set_bpm
//   - outputs: wrap pulse, below_half flag
//  FSM, step counter and output registers live in step_sequencer.
// TESTING (CLK_HZ=4, STEPS_PER_BEAT=1, MIN_BPM=30 => THRESH=240)
//  1. reset=0 for 2 cycles with play=1, set_bpm=60
//     -> timing=0, step_tick=0, bar_start=0, slow_clk=0 throughout.
//  2. set_bpm=60, play rises from IDLE
//     -> timing=1 with step_tick and bar_start on the next cycle.
//     -> timing then advances every 4 cycles 1..8.
//     -> 8->1 wrap pulses bar_start.
//  3. Drop play during step 3, 2 cycles after its tick, for 10 cycles
//     -> timing holds 3 with no ticks.
//     -> After play returns, step 4 ticks 2 cycles later.
//  4. set_bpm=0, play=1 -> step period is 8 cycles (clamped to 30 bpm).
//  5. rewind pulse with play=1 at timing=6
//     -> timing=0 next cycle, then timing=1 with bar_start on the cycle after.
//  6. set_bpm switched 60->120 mid-step
//     -> after a one-cycle lag, ticks arrive every 2 cycles; timing never skips a value.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared definitions for the drum timing and pattern datapath.
package drum_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPause} seq_state_e;

  localparam int unsigned NUM_STEPS   = 8;
  localparam logic [3:0]  TIMING_IDLE = 4'd0;
  localparam int unsigned BPM_W       = 8;

  // Floors a tempo at min_bpm; min_bpm must fit in BPM_W bits.
  function automatic logic [BPM_W-1:0] clamp_bpm(input logic [BPM_W-1:0] bpm,
                                                 input int unsigned      min_bpm);
    return (32'(bpm) < min_bpm) ? BPM_W'(min_bpm) : bpm;
  endfunction

endpackage

// File: rtl/bpm_phase_acc.sv
// Phase accumulator: adds the tempo increment each enabled cycle and wraps at one step period.
module bpm_phase_acc
  import drum_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned STEPS_PER_BEAT = 2,
  parameter int unsigned MIN_BPM        = 30,
  parameter int unsigned ACC_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [BPM_W-1:0] set_bpm,
  output logic             wrap,
  output logic             below_half
);

  localparam longint unsigned ThreshL  = longint'(CLK_HZ) * 60;
  localparam logic [ACC_W-1:0] Thresh   = ACC_W'(ThreshL);
  localparam logic [ACC_W-1:0] Half     = ACC_W'(ThreshL / 2);
  localparam logic [ACC_W-1:0] ResetInc = ACC_W'(MIN_BPM * STEPS_PER_BEAT);

  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum;

  always_comb begin
    inc_d = ACC_W'(clamp_bpm(set_bpm, MIN_BPM)) * ACC_W'(STEPS_PER_BEAT);
    sum   = acc_q + inc_q;
    wrap  = 1'b0;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      if (sum >= Thresh) begin
        wrap  = 1'b1;
        acc_d = sum - Thresh;
      end else begin
        acc_d = sum;
      end
    end
    // Judged on the next accumulator value so the registered square wave lines up with timing.
    below_half = (acc_d < Half);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      inc_q <= ResetInc;
      acc_q <= '0;
    end else begin
      inc_q <= inc_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Play/pause/idle step sequencer: drives the 1..8 step index and step-rate pulses.
module step_sequencer
  import drum_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned STEPS_PER_BEAT = 2,
  parameter int unsigned MIN_BPM        = 30,
  parameter int unsigned ACC_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             play,
  input  logic             rewind,
  input  logic [BPM_W-1:0] set_bpm,
  output logic [3:0]       timing,
  output logic             step_tick,
  output logic             bar_start,
  output logic             slow_clk
);

  localparam logic [3:0] LastStep = 4'(NUM_STEPS);

  seq_state_e state_q, state_d;
  logic [3:0] timing_q, timing_d;
  logic       tick_q, tick_d;
  logic       bar_q, bar_d;
  logic       slow_q, slow_d;
  logic       acc_en, acc_clr, acc_wrap, below_half;

  // Kept outside the FSM block so the wrap feedback is not a same-block loop.
  assign acc_clr = (state_q == StIdle) || rewind;
  assign acc_en  = (state_q == StRun) && play && !rewind;

  bpm_phase_acc #(
    .CLK_HZ        (CLK_HZ),
    .STEPS_PER_BEAT(STEPS_PER_BEAT),
    .MIN_BPM       (MIN_BPM),
    .ACC_W         (ACC_W)
  ) u_phase_acc (
    .clk       (clk),
    .reset     (reset),
    .en        (acc_en),
    .clr       (acc_clr),
    .set_bpm   (set_bpm),
    .wrap      (acc_wrap),
    .below_half(below_half)
  );

  always_comb begin
    state_d  = state_q;
    timing_d = timing_q;
    tick_d   = 1'b0;
    bar_d    = 1'b0;
    case (state_q)
      StIdle: begin
        timing_d = TIMING_IDLE;
        if (!rewind && play) begin
          state_d  = StRun;
          timing_d = 4'd1;
          tick_d   = 1'b1;
          bar_d    = 1'b1;
        end
      end
      StRun: begin
        if (rewind) begin
          state_d  = StIdle;
          timing_d = TIMING_IDLE;
        end else if (!play) begin
          state_d = StPause;
        end else if (acc_wrap) begin
          tick_d = 1'b1;
          if (timing_q == LastStep) begin
            timing_d = 4'd1;
            bar_d    = 1'b1;
          end else begin
            timing_d = timing_q + 4'd1;
          end
        end
      end
      StPause: begin
        if (rewind) begin
          state_d  = StIdle;
          timing_d = TIMING_IDLE;
        end else if (play) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d  = StIdle;
        timing_d = TIMING_IDLE;
      end
    endcase
    slow_d = (state_d != StIdle) && below_half;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      timing_q <= TIMING_IDLE;
      tick_q   <= 1'b0;
      bar_q    <= 1'b0;
      slow_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timing_q <= timing_d;
      tick_q   <= tick_d;
      bar_q    <= bar_d;
      slow_q   <= slow_d;
    end
  end

  assign timing    = timing_q;
  assign step_tick = tick_q;
  assign bar_start = bar_q;
  assign slow_clk  = slow_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer with a small tempo/step reference model.
module tb_step_sequencer;

  localparam int unsigned ClkHz  = 4;
  localparam int unsigned Spb    = 1;
  localparam int unsigned MinBpm = 30;
  localparam longint      Thresh = longint'(ClkHz) * 60;
  localparam longint      Half   = Thresh / 2;

  logic       clk;
  logic       reset;
  logic       play;
  logic       rewind;
  logic [7:0] set_bpm;
  logic [3:0] timing;
  logic       step_tick;
  logic       bar_start;
  logic       slow_clk;

  step_sequencer #(
    .CLK_HZ        (ClkHz),
    .STEPS_PER_BEAT(Spb),
    .MIN_BPM       (MinBpm),
    .ACC_W         (32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .play     (play),
    .rewind   (rewind),
    .set_bpm  (set_bpm),
    .timing   (timing),
    .step_tick(step_tick),
    .bar_start(bar_start),
    .slow_clk (slow_clk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] st;
    logic       tk;
    logic       br;
    logic       sl;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode 0 idle, 1 playing, 2 paused; step 0 means idle.
  int     m_mode = 0;
  int     m_step = 0;
  longint m_acc  = 0;
  longint m_inc  = longint'(MinBpm * Spb);
  bit     m_tick, m_bar, m_slow;

  task automatic cyc(input bit rst_n, input bit pl, input bit rw, input int bpm);
    longint new_inc;
    @(negedge clk);
    reset   = rst_n;
    play    = pl;
    rewind  = rw;
    set_bpm = bpm[7:0];
    new_inc = longint'((bpm < int'(MinBpm)) ? int'(MinBpm) : bpm) * longint'(Spb);
    m_tick  = 1'b0;
    m_bar   = 1'b0;
    if (!rst_n) begin
      m_mode = 0;
      m_step = 0;
      m_acc  = 0;
      m_inc  = longint'(MinBpm * Spb);
    end else begin
      if (m_mode == 0) begin
        m_acc = 0;
        if (pl && !rw) begin
          m_mode = 1;
          m_step = 1;
          m_tick = 1'b1;
          m_bar  = 1'b1;
        end
      end else if (rw) begin
        m_mode = 0;
        m_step = 0;
        m_acc  = 0;
      end else if (m_mode == 2) begin
        if (pl) m_mode = 1;
      end else if (!pl) begin
        m_mode = 2;
      end else begin
        m_acc = m_acc + m_inc;
        if (m_acc >= Thresh) begin
          m_acc  = m_acc - Thresh;
          m_step = (m_step % 8) + 1;
          m_tick = 1'b1;
          m_bar  = (m_step == 1);
        end
      end
      m_inc = new_inc;
    end
    m_slow = (m_mode != 0) && (m_acc < Half);
    exp_q.push_back('{st: 4'(m_step), tk: m_tick, br: m_bar, sl: m_slow});
  endtask

  // Monitor: every clock presents a fresh output word, compared against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = '{st: timing, tk: step_tick, br: bar_start, sl: slow_clk};
        checks++;
        if (a !== e || timing > 4'd8) begin
          failures++;
          $display("FAIL outputs t=%0t actual timing=%0d tick=%b bar=%b slow=%b required timing=%0d tick=%b bar=%b slow=%b",
                   $time, a.st, a.tk, a.br, a.sl, e.st, e.tk, e.br, e.sl);
        end
      end
    end
  end

  initial begin
    int bpm;
    reset   = 1'b0;
    play    = 1'b1;
    rewind  = 1'b0;
    set_bpm = 8'd60;

    // Reset held with play asserted.
    repeat (2) cyc(0, 1, 0, 60);
    repeat (3) cyc(1, 0, 0, 60);
    // Start and run through a full bar wrap.
    repeat (40) cyc(1, 1, 0, 60);
    // Pause two cycles after the step-3 tick.
    for (int i = 0; i < 100 && !(m_step == 3 && m_tick); i++) cyc(1, 1, 0, 60);
    repeat (2) cyc(1, 1, 0, 60);
    repeat (10) cyc(1, 0, 0, 60);
    repeat (12) cyc(1, 1, 0, 60);
    // Tempo below floor.
    repeat (20) cyc(1, 1, 0, 0);
    repeat (12) cyc(1, 1, 0, 15);
    // Rewind at step 6 with play held.
    for (int i = 0; i < 100 && !(m_step == 6 && m_tick); i++) cyc(1, 1, 0, 60);
    cyc(1, 1, 1, 60);
    repeat (6) cyc(1, 1, 0, 60);
    // Tempo change mid-step.
    for (int i = 0; i < 100 && !m_tick; i++) cyc(1, 1, 0, 60);
    repeat (2) cyc(1, 1, 0, 60);
    repeat (20) cyc(1, 1, 0, 120);
    // Rewind while running, then rewind+play in idle, then restart; reset mid-run.
    cyc(1, 1, 1, 60);
    cyc(1, 1, 1, 60);
    repeat (6) cyc(1, 1, 0, 60);
    cyc(0, 1, 0, 60);
    repeat (4) cyc(1, 1, 0, 60);

    bpm = 60;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) bpm = int'($urandom_range(0, 240));
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 59) == 0, bpm);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual pending=%0d required pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
